// File: rtl/rw_burst_sequencer_pkg.sv
// Shared types for the read/write burst sequencer: FSM states and phase ordering.
package rw_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    GAPW = 3'd2,
    PH2  = 3'd3,
    FIN  = 3'd4
  } state_e;

  typedef enum logic {
    WR_FIRST = 1'b0,
    RD_FIRST = 1'b1
  } mode_e;

endpackage

// File: rtl/rw_burst_sequencer_if.sv
// Request/strobe bundle between a requester (master) and the burst sequencer (slave).
interface rw_burst_sequencer_if #(
  parameter int MAX_LEN = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic             start;
  logic             mode;
  logic [LEN_W-1:0] wr_len;
  logic [LEN_W-1:0] rd_len;
  logic             wr;
  logic             rd;
  logic             busy;
  logic             done;
  logic             err_drop;

  modport master (
    output start, mode, wr_len, rd_len,
    input  wr, rd, busy, done, err_drop
  );

  modport slave (
    input  start, mode, wr_len, rd_len,
    output wr, rd, busy, done, err_drop
  );
endinterface

// File: rtl/rw_burst_sequencer_rise_det.sv
// Registers the start level and flags its 0->1 transition.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= i_d;
  end

  // Cleared register during reset lets a level held across release count as an edge.
  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/rw_burst_sequencer.sv
// Two-phase burst sequencer: emits a run of write/read strobes, optional gap, then the other kind.
module rw_burst_sequencer
  import rw_seq_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int GAP     = 0
) (
  input logic              clk,
  input logic              rst_n,
  rw_burst_sequencer_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_e           r_state, w_state_next;
  mode_e            r_mode, w_mode_next;
  logic [LEN_W-1:0] r_cnt, w_cnt_next;
  logic [LEN_W-1:0] r_len2, w_len2_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;
  logic             r_wr, r_rd, r_busy, r_done, r_err;
  logic             w_wr_next, w_rd_next, w_busy_next, w_done_next, w_err_next;
  logic             w_rise;
  logic [LEN_W-1:0] w_wl_clamp, w_rl_clamp, w_len1_new, w_len2_new;
  mode_e            w_mode_in;

  rise_det u_rise_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.start),
    .o_rise (w_rise)
  );

  assign w_wl_clamp = (bus.wr_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.wr_len;
  assign w_rl_clamp = (bus.rd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.rd_len;
  assign w_mode_in  = mode_e'(bus.mode);
  assign w_len1_new = (w_mode_in == WR_FIRST) ? w_wl_clamp : w_rl_clamp;
  assign w_len2_new = (w_mode_in == WR_FIRST) ? w_rl_clamp : w_wl_clamp;

  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_cnt_next   = r_cnt;
    w_len2_next  = r_len2;
    w_gap_next   = r_gap;
    w_err_next   = w_rise && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_mode_next = w_mode_in;
          w_len2_next = w_len2_new;
          // Empty phase 1 goes straight to phase 2, bypassing the gap.
          if (w_len1_new != '0) begin
            w_state_next = PH1;
            w_cnt_next   = w_len1_new;
          end else if (w_len2_new != '0) begin
            w_state_next = PH2;
            w_cnt_next   = w_len2_new;
          end else begin
            w_state_next = FIN;
          end
        end
      end
      PH1: begin
        if (r_cnt > LEN_W'(1)) begin
          w_cnt_next = r_cnt - LEN_W'(1);
        end else begin
          w_cnt_next = '0;
          if (r_len2 == '0) begin
            w_state_next = FIN;
          end else if (GAP > 0) begin
            w_state_next = GAPW;
            w_gap_next   = GAP_W'(GAP);
          end else begin
            w_state_next = PH2;
            w_cnt_next   = r_len2;
          end
        end
      end
      GAPW: begin
        if (r_gap > GAP_W'(1)) begin
          w_gap_next = r_gap - GAP_W'(1);
        end else begin
          w_gap_next   = '0;
          w_state_next = PH2;
          w_cnt_next   = r_len2;
        end
      end
      PH2: begin
        if (r_cnt > LEN_W'(1)) begin
          w_cnt_next = r_cnt - LEN_W'(1);
        end else begin
          w_cnt_next   = '0;
          w_state_next = FIN;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    w_busy_next = (w_state_next != IDLE);
    w_done_next = (w_state_next == FIN);
    w_wr_next   = ((w_state_next == PH1) && (w_mode_next == WR_FIRST)) ||
                  ((w_state_next == PH2) && (w_mode_next == RD_FIRST));
    w_rd_next   = ((w_state_next == PH1) && (w_mode_next == RD_FIRST)) ||
                  ((w_state_next == PH2) && (w_mode_next == WR_FIRST));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= WR_FIRST;
      r_cnt   <= '0;
      r_len2  <= '0;
      r_gap   <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_cnt   <= w_cnt_next;
      r_len2  <= w_len2_next;
      r_gap   <= w_gap_next;
      r_wr    <= w_wr_next;
      r_rd    <= w_rd_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign bus.wr       = r_wr;
  assign bus.rd       = r_rd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err_drop = r_err;
endmodule

// File: tb/tb_rw_burst_sequencer.sv
// Scoreboard bench: two sequencers (GAP=0 and GAP=2) checked cycle by cycle against queued expectations.
module tb_rw_burst_sequencer;
  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  // Vector layout: {wr, rd, busy, done, err_drop}
  logic [4:0] exp_q[$];

  rw_burst_sequencer_if #(.MAX_LEN(16)) bus0 ();
  rw_burst_sequencer_if #(.MAX_LEN(16)) bus2 ();

  rw_burst_sequencer #(.MAX_LEN(16), .GAP(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  rw_burst_sequencer #(.MAX_LEN(16), .GAP(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] obs(input int sel);
    if (sel == 0) return {bus0.wr, bus0.rd, bus0.busy, bus0.done, bus0.err_drop};
    else          return {bus2.wr, bus2.rd, bus2.busy, bus2.done, bus2.err_drop};
  endfunction

  task automatic set_in(input int sel, input logic s, input logic m,
                        input logic [4:0] wl, input logic [4:0] rl);
    if (sel == 0) begin
      bus0.start = s; bus0.mode = m; bus0.wr_len = wl; bus0.rd_len = rl;
    end else begin
      bus2.start = s; bus2.mode = m; bus2.wr_len = wl; bus2.rd_len = rl;
    end
  endtask

  task automatic set_start(input int sel, input logic s);
    if (sel == 0) bus0.start = s;
    else          bus2.start = s;
  endtask

  task automatic push_expected(input int gap, input logic m, input int wl, input int rl);
    int l1, l2;
    logic [4:0] s1, s2;
    l1 = m ? rl : wl;
    l2 = m ? wl : rl;
    if (l1 > 16) l1 = 16;
    if (l2 > 16) l2 = 16;
    s1 = m ? 5'b01100 : 5'b10100;
    s2 = m ? 5'b10100 : 5'b01100;
    for (int i = 0; i < l1; i++) exp_q.push_back(s1);
    if (l1 > 0 && l2 > 0)
      for (int i = 0; i < gap; i++) exp_q.push_back(5'b00100);
    for (int i = 0; i < l2; i++) exp_q.push_back(s2);
    exp_q.push_back(5'b00110);
  endtask

  // Drives one start edge and checks every following cycle against the scoreboard.
  // drop_idx: cycle index at which a second start edge is presented (-1 = none).
  // rst_idx : cycle index at which reset is asserted for two cycles (-1 = none).
  task automatic run_txn(input string name, input int sel, input int gap, input logic m,
                         input int wl, input int rl, input int drop_idx,
                         input bit hold, input int rst_idx);
    logic [4:0] e, o;
    int idx;
    int fails_before;
    fails_before = n_fail;
    exp_q.delete();
    push_expected(gap, m, wl, rl);
    if (drop_idx >= 0) begin
      while (exp_q.size() <= drop_idx + 1) exp_q.push_back(5'b00000);
      exp_q[drop_idx + 1] = exp_q[drop_idx + 1] | 5'b00001;
    end
    if (rst_idx >= 0)
      for (int i = rst_idx + 1; i < exp_q.size(); i++) exp_q[i] = 5'b00000;

    @(negedge clk);
    rst_n = 1'b1;
    set_in(sel, 1'b1, m, 5'(wl), 5'(rl));
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs(sel);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle k+%0d: got wr,rd,busy,done,err=%b required %b", name, idx + 1, o, e);
      end
      if (hold)                  set_start(sel, 1'b1);
      else if (idx == drop_idx)  set_start(sel, 1'b1);
      else                       set_start(sel, 1'b0);
      if (rst_idx >= 0 && idx == rst_idx)     rst_n = 1'b0;
      if (rst_idx >= 0 && idx == rst_idx + 2) rst_n = 1'b1;
      idx++;
    end
    for (int i = 0; i < (hold ? 3 : 1); i++) begin
      @(negedge clk);
      o = obs(sel);
      n_checks++;
      if (o !== 5'b00000) begin
        n_fail++;
        $display("FAIL %s idle after: got %b required 00000", name, o);
      end
    end
    set_start(sel, 1'b0);
    rst_n = 1'b1;
    $display("txn %s sel=%0d mode=%0d wr_len=%0d rd_len=%0d cycles=%0d errors=%0d",
             name, sel, m, wl, rl, idx, n_fail - fails_before);
  endtask

  task automatic test_reset;
    logic [4:0] o;
    rst_n = 1'b0;
    set_in(0, 1'b1, 1'b0, 5'd1, 5'd1);
    set_in(2, 1'b0, 1'b0, 5'd0, 5'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        o = obs(s * 2);
        n_checks++;
        if (o !== 5'b00000) begin
          n_fail++;
          $display("FAIL reset_state sel=%0d: got %b required 00000", s * 2, o);
        end
      end
    end
    // Start stays high through release: the first edge afterwards must trigger.
    run_txn("start_across_reset", 0, 0, 1'b0, 1, 1, -1, 1'b0, -1);
  endtask

  task automatic test_basic;
    run_txn("wr1_rd2_gap0", 0, 0, 1'b0, 1, 2, -1, 1'b0, -1);
    run_txn("rd_first_gap0", 0, 0, 1'b1, 2, 3, -1, 1'b0, -1);
  endtask

  task automatic test_gap;
    run_txn("rd1_wr3_gap2", 2, 2, 1'b1, 3, 1, -1, 1'b0, -1);
    run_txn("empty_ph1_gap2", 2, 2, 1'b0, 0, 3, -1, 1'b0, -1);
  endtask

  task automatic test_zero_len;
    run_txn("both_zero", 0, 0, 1'b0, 0, 0, -1, 1'b0, -1);
    run_txn("both_zero_gap2", 2, 2, 1'b1, 0, 0, -1, 1'b0, -1);
  endtask

  task automatic test_drop;
    run_txn("drop_in_ph1", 0, 0, 1'b0, 4, 0, 1, 1'b0, -1);
    run_txn("drop_in_fin", 2, 2, 1'b0, 2, 0, 2, 1'b0, -1);
  endtask

  task automatic test_clamp;
    run_txn("clamp_wr20", 0, 0, 1'b0, 20, 0, -1, 1'b0, -1);
    run_txn("clamp_rd31", 2, 2, 1'b0, 1, 31, -1, 1'b0, -1);
  endtask

  task automatic test_hold;
    run_txn("start_held", 0, 0, 1'b0, 2, 1, -1, 1'b1, -1);
  endtask

  task automatic test_reset_mid;
    run_txn("reset_in_ph2", 0, 0, 1'b0, 2, 4, -1, 1'b0, 2);
    run_txn("after_reset", 0, 0, 1'b0, 1, 2, -1, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    run_txn("b2b_a", 2, 2, 1'b0, 2, 2, -1, 1'b0, -1);
    run_txn("b2b_b", 2, 2, 1'b1, 1, 16, -1, 1'b0, -1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_in(0, 1'b0, 1'b0, 5'd0, 5'd0);
    set_in(2, 1'b0, 1'b0, 5'd0, 5'd0);
    test_reset();
    test_basic();
    test_gap();
    test_zero_len();
    test_drop();
    test_clamp();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rw_burst_sequencer.md
RW_BURST_SEQUENCER -- requirements
Module: rw_burst_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, giving the maximum beats per phase (>=1).
REQ-002 The block SHALL have parameter GAP, default 0, giving the idle cycles between phase 1 and phase 2 (>=0).
REQ-003 The block SHALL have localparam LEN_W = $clog2(MAX_LEN+1), the length field width.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port start  input  1  request level; a transaction is triggered by its rising edge.
REQ-007 The block SHALL have port mode  input  1  0 = write phase then read phase, 1 = read phase then write phase.
REQ-008 The block SHALL have port wr_len  input  LEN_W  write beat count.
REQ-009 The block SHALL have port rd_len  input  LEN_W  read beat count.
REQ-010 The block SHALL have port wr  output  1  write strobe, one beat per cycle.
REQ-011 The block SHALL have port rd  output  1  read strobe, one beat per cycle.
REQ-012 The block SHALL have port busy  output  1  transaction in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port err_drop  output  1  one-cycle pulse when a start edge is dropped.

Function
REQ-015 The block SHALL register start into start_q; rise = start & ~start_q, evaluated at each posedge.
REQ-016 The block SHALL implement FSM states IDLE, PH1, GAPW, PH2, FIN; all outputs SHALL be registered (Moore).
REQ-017 On rise in IDLE, the block SHALL latch mode, wr_len and rd_len, with a length > MAX_LEN clamped to MAX_LEN.
REQ-018 Phase 1 SHALL be the write beats (mode 0) or the read beats (mode 1); phase 2 SHALL be the other kind.
REQ-019 The first phase-1 beat SHALL appear in the cycle after the edge that sampled rise (|=> timing).
REQ-020 Each phase SHALL assert its strobe for exactly its latched length in consecutive cycles.
REQ-021 GAPW SHALL last exactly GAP cycles and SHALL be skipped when GAP = 0, so phase 2 follows phase 1 back-to-back.
REQ-022 A phase with length 0 SHALL be skipped entirely; if both lengths are 0, FIN SHALL follow IDLE directly.
REQ-023 When phase 1 is empty, GAPW SHALL also be skipped.
REQ-024 FIN SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in PH1, GAPW, PH2 and FIN, and 0 in IDLE.
REQ-026 wr and rd SHALL never be 1 in the same cycle.
REQ-027 A rise while busy=1 (including during FIN) SHALL be ignored and SHALL cause err_drop=1 in the following cycle; the transaction in flight SHALL be unaffected.
REQ-028 A start level held high SHALL NOT retrigger; only a new 0->1 edge triggers.
REQ-029 The beat counter SHALL be LEN_W wide, count down from the latched length, and never wrap.

Reset
REQ-030 While rst_n=0 at a posedge, the FSM SHALL go to IDLE and wr, rd, busy, done, err_drop, start_q and the counters SHALL all become 0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no done pulse.
REQ-032 A start held high across reset release SHALL count as a rise on the first edge after release.

Structure
REQ-033 Package rw_seq_pkg SHALL hold the state enum (IDLE, PH1, GAPW, PH2, FIN) and the mode enum (WR_FIRST=0, RD_FIRST=1).
REQ-034 A single sub-module, rise_det (start_q register plus edge output, synchronous active-low reset), SHALL be instantiated once.

Verification (start rise sampled at edge k)
REQ-035 Scenario: MAX_LEN=16, GAP=0, mode=0, wr_len=1, rd_len=2 -> wr at k+1, rd at k+2 and k+3, done at k+4, busy k+1..k+4, no wr/rd overlap.
REQ-036 Scenario: GAP=2, mode=1, wr_len=3, rd_len=1 -> rd at k+1, idle k+2 and k+3, wr k+4..k+6, done at k+7.
REQ-037 Scenario: wr_len=0, rd_len=0 -> no strobes, done at k+1, busy only at k+1.
REQ-038 Scenario: wr_len=4, second start edge sampled at k+2 -> err_drop at k+3 only; the beat pattern is identical to a single request.
REQ-039 Scenario: wr_len=20 with MAX_LEN=16 -> exactly 16 wr beats.
REQ-040 Scenario: rst_n=0 sampled during PH2 -> the next cycle has all outputs 0, no done pulse, and a fresh start edge works normally afterwards.
